median_window_feeder: RTL and testbench
=======================================

Name: median_window_feeder

Overview:
- Upstream stage of the median filter datapath.
- Buffers an incoming raster pixel stream in a 3-line ring memory.
- For every pixel position, serialises its 3x3 neighbourhood (9 pixels) onto the median sorter's data/select interface, then waits for the sorter's done pulse before issuing the next window.
- Reports the window centre coordinates and a frame-done pulse.

Parameters:
- WIDTH, 8, bits per pixel.
- IMG_W, 16, pixels per line (>=2).
- IMG_H, 16, lines per frame (>=2).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- PIX_I  in  WIDTH  incoming raster pixel.
- PIX_VLD  in  1  PIX_I valid.
- PIX_RDY  out  1  feeder accepts PIX_I; transfer when PIX_VLD&&PIX_RDY.
- MDI  out  WIDTH  pixel to sorter data input.
- MDSI  out  1  sorter data-select; high for exactly 9 consecutive cycles per window.
- MDSO  in  1  sorter done pulse (1 cycle).
- WIN_ROW  out  $clog2(IMG_H)  centre row of the window in flight.
- WIN_COL  out  $clog2(IMG_W)  centre column of the window in flight.
- FRAME_DONE  out  1  1-cycle pulse after the last window's MDSO.

Behaviour:
- Reset (async, nRST=0): state IDLE, all counters 0, PIX_RDY=0 until the first clock after release, MDSI=0, MDI=0, WIN_ROW=WIN_COL=0, FRAME_DONE=0. Memory contents are not reset.
- Storage: 3*IMG_W entries; line r is written to slot r mod 3, column c.
- States:
  - IDLE: PIX_RDY=1. The first accepted pixel is written to (0,0) -> LOAD.
  - LOAD: PIX_RDY=1. Accepts pixels in raster order with a column counter that wraps at IMG_W-1 and increments the load row. Line 0 complete -> stay in LOAD. Line L>=1 complete -> SEND for centre row L-1, with WIN_COL=0.
  - SEND: PIX_RDY=0, MDSI=1 for 9 cycles (tap counter 0..8). MDI order is row offset -1,0,+1 (outer) by column offset -1,0,+1 (inner). Coordinates are clamped to [0,IMG_H-1]/[0,IMG_W-1], so borders replicate. MDI is driven registered, aligned with MDSI. After tap 8 -> WAIT.
  - WAIT: MDSI=0, MDI holds its last value, PIX_RDY=0, waiting for MDSO.
    - On MDSO: if WIN_COL<IMG_W-1, increment WIN_COL -> SEND.
    - Else, if centre row < IMG_H-2 -> LOAD (next line).
    - Else, if centre row == IMG_H-2 -> SEND for centre row IMG_H-1 with no load.
    - Else (centre row == IMG_H-1) -> DONE.
  - DONE: FRAME_DONE=1 for one cycle -> IDLE.
- The ring never overwrites a line still needed: the load of line L+1 starts only after all windows of centre row L-1 are done.
- MDSI is guaranteed low for at least one cycle between windows (the WAIT state).
- MDSO received outside WAIT is ignored.
- PIX_VLD while PIX_RDY=0 is not consumed; the producer must hold the pixel.
- Throughput: 9 + sorter latency + 1 cycles per window.
- Reset mid-frame returns to IDLE immediately; the partial frame is discarded.

Optional Feature:
- Macro MEDIAN_FEEDER_ZERO_PAD_EN.
- Defined: any out-of-image neighbour tap drives MDI=0 instead of the clamped pixel. MDSI timing is unchanged (still 9 cycles).
- Undefined: edge replication as described above.

Test Plan:
- IMG_W=4, IMG_H=3, pixel value = 4*row+col, PIX_VLD always 1. The first window (0,0) emits MDI = 0,0,1,0,0,1,4,4,5 with MDSI high exactly 9 cycles and WIN_ROW=0, WIN_COL=0.
- Same frame, sorter model returns MDSO 30 cycles after MDSI falls. Exactly 12 windows are issued; window (1,1) emits 0,1,2,4,5,6,8,9,10. FRAME_DONE pulses once, one cycle after the 12th MDSO.
- PIX_VLD toggled randomly during LOAD. Loaded data and window contents are identical to the first test, and PIX_RDY=0 throughout every SEND and WAIT.
- Spurious MDSO pulse in LOAD and mid-SEND. No state change: the window still emits 9 taps and waits for a real MDSO.
- nRST asserted at the 5th tap of window (1,2). MDSI=0 and PIX_RDY=0 during reset. After release, a new frame is accepted from (0,0) and reproduces the first test's output.
- With MEDIAN_FEEDER_ZERO_PAD_EN defined and the first test's stimulus, window (0,0) emits 0,0,0,0,0,1,0,4,5.

Source files
------------

// File: rtl/median_window_feeder_if.sv
// Pixel-stream and sorter-side signals of the median window feeder.
// slave = the feeder itself, master = the pixel producer / sorter environment.
interface median_window_feeder_if #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [WIDTH-1:0] PIX_I;
  logic             PIX_VLD;
  logic             PIX_RDY;
  logic [WIDTH-1:0] MDI;
  logic             MDSI;
  logic             MDSO;
  logic [RW-1:0]    WIN_ROW;
  logic [CW-1:0]    WIN_COL;
  logic             FRAME_DONE;

  modport slave (
    input  PIX_I, PIX_VLD, MDSO,
    output PIX_RDY, MDI, MDSI, WIN_ROW, WIN_COL, FRAME_DONE
  );

  modport master (
    output PIX_I, PIX_VLD, MDSO,
    input  PIX_RDY, MDI, MDSI, WIN_ROW, WIN_COL, FRAME_DONE
  );
endinterface

// File: rtl/median_window_feeder.sv
// Buffers a raster stream in a 3-line ring and serialises each 3x3 window to the median sorter.
// Define MEDIAN_FEEDER_ZERO_PAD_EN to drive 0 for out-of-image taps instead of replicating edges.
//
// state | meaning
// IDLE  | frame start, waiting for pixel (0,0)
// LOAD  | accepting one raster line into the ring
// SEND  | streaming 9 taps of the current window (MDSI high one cycle later)
// WAIT  | taps sent, waiting for the sorter done pulse
// DONE  | one-cycle frame-done pulse
module median_window_feeder #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  median_window_feeder_if.slave  bus
);
  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);
  localparam int DEPTH = 3 * IMG_W;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [1:0]       slot_q, slot_d;
  logic [RW-1:0]    win_row_q, win_row_d;
  logic [CW-1:0]    win_col_q, win_col_d;
  logic [3:0]       tap_q, tap_d;
  logic [WIDTH-1:0] mdi_q, mdi_d;
  logic             mdsi_q, mdsi_d;
  logic             rdy_q, rdy_d;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] tap_pix;
  int               tap_r, tap_c, rd_r, rd_c;

  logic [WIDTH-1:0] line_mem [DEPTH];

  assign wr_addr = AW'(int'(slot_q) * IMG_W + int'(col_q));

  always_ff @(posedge CLK) begin
    if (wr_en) line_mem[wr_addr] <= bus.PIX_I;
  end

  // Neighbour coordinates for the current tap; reads clamp into the image.
  always_comb begin
    tap_r   = int'(win_row_q) + int'(tap_q) / 3 - 1;
    tap_c   = int'(win_col_q) + int'(tap_q) % 3 - 1;
    rd_r    = (tap_r < 0) ? 0 : ((tap_r > IMG_H - 1) ? IMG_H - 1 : tap_r);
    rd_c    = (tap_c < 0) ? 0 : ((tap_c > IMG_W - 1) ? IMG_W - 1 : tap_c);
    rd_addr = AW'((rd_r % 3) * IMG_W + rd_c);
    tap_pix = line_mem[rd_addr];
`ifdef MEDIAN_FEEDER_ZERO_PAD_EN
    if (tap_r < 0 || tap_r > IMG_H - 1 || tap_c < 0 || tap_c > IMG_W - 1) tap_pix = '0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    slot_d    = slot_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    tap_d     = tap_q;
    mdi_d     = mdi_q;
    mdsi_d    = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (bus.PIX_VLD && rdy_q) begin
          wr_en   = 1'b1;
          state_d = S_LOAD;
          if (col_q == CW'(IMG_W - 1)) begin
            col_d  = '0;
            row_d  = row_q + 1'b1;
            slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
            // Line L complete: all three rows for centre L-1 are now resident.
            if (row_q != '0) begin
              state_d   = S_SEND;
              win_row_d = row_q - 1'b1;
              win_col_d = '0;
              tap_d     = '0;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_SEND: begin
        mdsi_d = 1'b1;
        mdi_d  = tap_pix;
        if (tap_q == 4'd8) state_d = S_WAIT;
        else tap_d = tap_q + 4'd1;
      end
      S_WAIT: begin
        if (bus.MDSO) begin
          tap_d = '0;
          if (win_col_q != CW'(IMG_W - 1)) begin
            win_col_d = win_col_q + 1'b1;
            state_d   = S_SEND;
          end else if (int'(win_row_q) < IMG_H - 2) begin
            state_d = S_LOAD;
          end else if (int'(win_row_q) == IMG_H - 2) begin
            win_row_d = win_row_q + 1'b1;
            win_col_d = '0;
            state_d   = S_SEND;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        col_d     = '0;
        row_d     = '0;
        slot_d    = '0;
        win_row_d = '0;
        win_col_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      slot_q    <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
      tap_q     <= '0;
      mdi_q     <= '0;
      mdsi_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      slot_q    <= slot_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      tap_q     <= tap_d;
      mdi_q     <= mdi_d;
      mdsi_q    <= mdsi_d;
      rdy_q     <= rdy_d;
    end
  end

  assign bus.PIX_RDY    = rdy_q;
  assign bus.MDI        = mdi_q;
  assign bus.MDSI       = mdsi_q;
  assign bus.WIN_ROW    = win_row_q;
  assign bus.WIN_COL    = win_col_q;
  assign bus.FRAME_DONE = (state_q == S_DONE);
endmodule

// File: tb/tb_median_window_feeder.sv
// Self-checking bench for median_window_feeder on a 4x3 image with a sorter model.
module tb_median_window_feeder;
  localparam int WIDTH = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int NWIN  = IMG_W * IMG_H;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  median_window_feeder_if #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();
  median_window_feeder #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]        row;
    logic [1:0]        col;
    logic [0:8][7:0]   exp;
  } win_vec_t;

  win_vec_t tbl [4];
  int checks   = 0;
  int failures = 0;
  int pix_model [IMG_H][IMG_W];
  int cap [NWIN][9];
  int fd_count;
  bit aborted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference window tap straight from the 3x3 neighbourhood definition.
  function automatic int exp_tap(input int r, input int c, input int t);
    int rr = r + t / 3 - 1;
    int cc = c + t % 3 - 1;
    if (rr < 0 || rr >= IMG_H || cc < 0 || cc >= IMG_W) begin
`ifdef MEDIAN_FEEDER_ZERO_PAD_EN
      return 0;
`else
      rr = (rr < 0) ? 0 : ((rr >= IMG_H) ? IMG_H - 1 : rr);
      cc = (cc < 0) ? 0 : ((cc >= IMG_W) ? IMG_W - 1 : cc);
`endif
    end
    return pix_model[rr][cc];
  endfunction

  always @(negedge CLK) if (bus.FRAME_DONE === 1'b1) fd_count++;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic producer(input bit rand_vld);
    int idx = 0;
    int guard = 0;
    while (idx < NWIN && !aborted && guard < 3000) begin
      @(negedge CLK);
      guard++;
      bus.PIX_VLD = rand_vld ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.PIX_I   = WIDTH'(pix_model[idx / IMG_W][idx % IMG_W]);
      if (bus.PIX_VLD && bus.PIX_RDY) idx++;
    end
    if (guard >= 3000) check("producer_timeout", 32'(idx), 32'(NWIN));
    @(posedge CLK);
    #1 bus.PIX_VLD = 1'b0;
  endtask

  task automatic consumer(input int delay, input bit spur, input int abort_w);
    for (int w = 0; w < NWIN; w++) begin
      int g = 0;
      int n = 0;
      int d;
      bit spurred = 0;
      bit bad_rdy = 0;
      bit bad_coord = 0;
      bit bad_gap = 0;
      forever begin
        @(negedge CLK);
        g++;
        bus.MDSO = 1'b0;
        if (bus.MDSI || g >= 500) break;
        if (spur && bus.PIX_RDY && !spurred) begin
          bus.MDSO = 1'b1;
          spurred = 1;
        end
      end
      if (!bus.MDSI) begin
        check("mdsi_rise_timeout", 32'(g), 32'(0));
        return;
      end
      while (bus.MDSI && n < 20) begin
        if (n < 9) cap[w][n] = int'(bus.MDI);
        if (int'(bus.WIN_ROW) != w / IMG_W || int'(bus.WIN_COL) != w % IMG_W) bad_coord = 1;
        if (bus.PIX_RDY) bad_rdy = 1;
        if (w == abort_w && n == 4) begin
          nRST = 1'b0;
          #1;
          check("rst_mdsi", 32'(bus.MDSI), 32'(0));
          check("rst_rdy", 32'(bus.PIX_RDY), 32'(0));
          check("rst_mdi", 32'(bus.MDI), 32'(0));
          check("rst_win", {bus.WIN_ROW, bus.WIN_COL}, 32'(0));
          @(negedge CLK);
          check("rst_hold", {bus.MDSI, bus.PIX_RDY, bus.FRAME_DONE}, 32'(0));
          nRST = 1'b1;
          aborted = 1;
          return;
        end
        bus.MDSO = (spur && n == 3);
        n++;
        @(negedge CLK);
      end
      bus.MDSO = 1'b0;
      check("tap_count", 32'(n), 32'(9));
      for (int t = 0; t < 9; t++)
        check($sformatf("tap w%0d t%0d", w, t), 32'(cap[w][t]), 32'(exp_tap(w / IMG_W, w % IMG_W, t)));
      d = (delay >= 0) ? delay : int'($urandom_range(0, 5));
      for (int i = 0; i < d; i++) begin
        @(negedge CLK);
        if (bus.MDSI) bad_gap = 1;
        if (bus.PIX_RDY) bad_rdy = 1;
      end
      if (bus.PIX_RDY) bad_rdy = 1;
      bus.MDSO = 1'b1;
      @(negedge CLK);
      bus.MDSO = 1'b0;
      check("frame_done_timing", 32'(bus.FRAME_DONE), 32'(w == NWIN - 1));
      check("rdy_low_send_wait", 32'(bad_rdy), 32'(0));
      check("win_coord", 32'(bad_coord), 32'(0));
      check("mdsi_gap", 32'(bad_gap), 32'(0));
    end
  endtask

  task automatic run_frame(input bit rand_vld, input bit rand_data, input int delay,
                           input bit spur, input int abort_w);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix_model[r][c] = rand_data ? int'($urandom_range(0, 255)) : 4 * r + c;
    aborted  = 0;
    fd_count = 0;
    fork
      producer(rand_vld);
      consumer(delay, spur, abort_w);
    join
    @(negedge CLK);
    @(negedge CLK);
    check("frame_done_pulses", 32'(fd_count), 32'(abort_w < 0 ? 1 : 0));
  endtask

  task automatic compare_table(input string tag);
    for (int i = 0; i < 4; i++)
      for (int t = 0; t < 9; t++)
        check($sformatf("%s win(%0d,%0d) t%0d", tag, tbl[i].row, tbl[i].col, t),
              32'(cap[int'(tbl[i].row) * IMG_W + int'(tbl[i].col)][t]), 32'(tbl[i].exp[t]));
  endtask

  initial begin
`ifdef MEDIAN_FEEDER_ZERO_PAD_EN
    tbl[0] = '{row: 2'd0, col: 2'd0, exp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd4, 8'd5}};
    tbl[2] = '{row: 2'd0, col: 2'd3, exp: {8'd0, 8'd0, 8'd0, 8'd2, 8'd3, 8'd0, 8'd6, 8'd7, 8'd0}};
    tbl[3] = '{row: 2'd2, col: 2'd3, exp: {8'd6, 8'd7, 8'd0, 8'd10, 8'd11, 8'd0, 8'd0, 8'd0, 8'd0}};
`else
    tbl[0] = '{row: 2'd0, col: 2'd0, exp: {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd4, 8'd4, 8'd5}};
    tbl[2] = '{row: 2'd0, col: 2'd3, exp: {8'd2, 8'd3, 8'd3, 8'd2, 8'd3, 8'd3, 8'd6, 8'd7, 8'd7}};
    tbl[3] = '{row: 2'd2, col: 2'd3, exp: {8'd6, 8'd7, 8'd7, 8'd10, 8'd11, 8'd11, 8'd10, 8'd11, 8'd11}};
`endif
    tbl[1] = '{row: 2'd1, col: 2'd1, exp: {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}};

    bus.PIX_I   = '0;
    bus.PIX_VLD = 1'b0;
    bus.MDSO    = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_rdy", 32'(bus.PIX_RDY), 32'(0));
    check("reset_mdsi", 32'(bus.MDSI), 32'(0));
    check("reset_mdi", 32'(bus.MDI), 32'(0));
    check("reset_win", {bus.WIN_ROW, bus.WIN_COL}, 32'(0));
    check("reset_frame_done", 32'(bus.FRAME_DONE), 32'(0));
    nRST = 1'b1;
    #1 check("rdy_before_first_clk", 32'(bus.PIX_RDY), 32'(0));
    @(negedge CLK);
    check("rdy_after_first_clk", 32'(bus.PIX_RDY), 32'(1));

    run_frame(0, 0, 30, 0, -1);
    compare_table("basic");
    run_frame(1, 0, -1, 0, -1);
    compare_table("rand_vld");
    run_frame(1, 0, -1, 1, -1);
    compare_table("spurious");
    run_frame(1, 1, -1, 0, -1);
    run_frame(0, 0, 30, 0, 6);
    run_frame(0, 0, 30, 0, -1);
    compare_table("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
